// File: rtl/run_det_pkg.sv
// run_det_pkg: shared constants and helpers for the Moore run detector.
//   OVL_ON / OVL_OFF : encodings of the ovl (overlap mode) input.
//   cw_of()          : width of a per-channel run counter that must hold
//                      states 0..run_len inclusive.
package run_det_pkg;

    localparam logic OVL_ON  = 1'b1;
    localparam logic OVL_OFF = 1'b0;

    function automatic int cw_of(input int run_len);
        return $clog2(run_len + 1);
    endfunction

endpackage

// File: rtl/run_det_chan.sv
// run_det_chan: one channel of the run detector.
//   Moore FSM with states S0..S(RUN_LEN), encoded directly as the count of
//   current consecutive matches, plus a saturating hit counter.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   en           : sample enable (low = run state holds)
//   w            : serial input bit for this channel
//   pol          : target value; a sample matches when w == pol
//   ovl          : 1 = overlapping runs, 0 = non-overlapping
//   clr          : synchronous clear of the hit counter (ignores en)
//   z            : registered detect flag, 1 while in S(RUN_LEN)
//   run_cnt      : registered run state index
//   hit_cnt      : registered saturating hit count
module run_det_chan
    import run_det_pkg::*;
#(
    parameter int RUN_LEN = 2,
    parameter int HW      = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       w,
    input  logic                       pol,
    input  logic                       ovl,
    input  logic                       clr,
    output logic                       z,
    output logic [cw_of(RUN_LEN)-1:0]  run_cnt,
    output logic [HW-1:0]              hit_cnt
);

    localparam int CW = cw_of(RUN_LEN);
    localparam logic [CW-1:0] ST_ZERO = CW'(0);
    localparam logic [CW-1:0] ST_ONE  = CW'(1);
    localparam logic [CW-1:0] ST_LAST = CW'(RUN_LEN - 1);
    localparam logic [CW-1:0] ST_FULL = CW'(RUN_LEN);
    localparam logic [HW-1:0] HIT_MAX = {HW{1'b1}};

    logic [CW-1:0] run_d, run_q;
    logic [HW-1:0] hit_d, hit_q;
    logic          z_d, z_q;
    logic          match_s;
    logic          hit_inc_s;

    // Next-state, hit-increment and next-z decode for this channel.
    always_comb begin
        run_d     = run_q;
        hit_d     = hit_q;
        hit_inc_s = 1'b0;
        match_s   = (w == pol);

        if (en) begin
            if (!match_s) begin
                run_d = ST_ZERO;
            end else if (run_q != ST_FULL) begin
                run_d = run_q + ST_ONE;
                // Completing a run from S(RUN_LEN-1) is a hit.
                hit_inc_s = (run_q == ST_LAST);
            end else if (ovl == OVL_ON) begin
                run_d     = ST_FULL;
                hit_inc_s = 1'b1;
            end else begin
                // Non-overlapping: the matching sample starts a fresh run.
                run_d = ST_ONE;
            end
        end else begin
            run_d = run_q;
        end

        // clr wins over a simultaneous increment.
        if (clr) begin
            hit_d = {HW{1'b0}};
        end else if (hit_inc_s && (hit_q != HIT_MAX)) begin
            hit_d = hit_q + {{(HW-1){1'b0}}, 1'b1};
        end else begin
            hit_d = hit_q;
        end

        // z is registered alongside the state so it equals (run_q == FULL).
        z_d = (run_d == ST_FULL);
    end

    // Channel state, hit counter and detect flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q <= ST_ZERO;
            hit_q <= {HW{1'b0}};
            z_q   <= 1'b0;
        end else begin
            run_q <= run_d;
            hit_q <= hit_d;
            z_q   <= z_d;
        end
    end

    assign z       = z_q;
    assign run_cnt = run_q;
    assign hit_cnt = hit_q;

endmodule

// File: rtl/moore_run_detector.sv
// moore_run_detector: CH independent run detectors sharing en/pol/ovl/clr.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   en           : sample enable for all channels
//   w[CH]        : per-channel serial inputs
//   pol          : target bit value
//   ovl          : overlapping (1) / non-overlapping (0) run mode
//   clr          : synchronous clear of all hit counters
//   z[CH]        : per-channel registered detect flags
//   run_cnt      : per-channel run state, channel i at [i*CW +: CW]
//   hit_cnt      : per-channel hit count, channel i at [i*HW +: HW]
//   any_z        : OR of all z bits
module moore_run_detector
    import run_det_pkg::*;
#(
    parameter int CH      = 4,
    parameter int RUN_LEN = 2,
    parameter int HW      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [CH-1:0]                 w,
    input  logic                          pol,
    input  logic                          ovl,
    input  logic                          clr,
    output logic [CH-1:0]                 z,
    output logic [CH*cw_of(RUN_LEN)-1:0]  run_cnt,
    output logic [CH*HW-1:0]              hit_cnt,
    output logic                          any_z
);

    localparam int CW = cw_of(RUN_LEN);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        run_det_chan #(
            .RUN_LEN (RUN_LEN),
            .HW      (HW)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .en      (en),
            .w       (w[i]),
            .pol     (pol),
            .ovl     (ovl),
            .clr     (clr),
            .z       (z[i]),
            .run_cnt (run_cnt[i*CW +: CW]),
            .hit_cnt (hit_cnt[i*HW +: HW])
        );
    end

    assign any_z = |z;

endmodule

// File: doc/moore_run_detector.md
MOORE_RUN_DETECTOR -- requirements
Module: moore_run_detector

Interface
REQ-001 SHALL have parameter CH, default 4, number of independent input channels (>=1).
REQ-002 SHALL have parameter RUN_LEN, default 2, consecutive matching samples needed to assert z (>=2).
REQ-003 SHALL have parameter HW, default 8, width of each per-channel hit counter (>=2).
REQ-004 SHALL have port clk  input  1  clock, all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port en  input  1  sample enable; low = all channel state holds.
REQ-007 SHALL have port w  input  CH  per-channel serial input bit.
REQ-008 SHALL have port pol  input  1  target value; a sample matches when w[i]==pol.
REQ-009 SHALL have port ovl  input  1  1 = overlapping runs, 0 = non-overlapping.
REQ-010 SHALL have port clr  input  1  synchronous clear of all hit counters.
REQ-011 SHALL have port z  output  CH  per-channel Moore detect flag.
REQ-012 SHALL have port run_cnt  output  CH*CW  per-channel run state, CW=$clog2(RUN_LEN+1), channel i at bits [i*CW +: CW].
REQ-013 SHALL have port hit_cnt  output  CH*HW  per-channel hit count, channel i at bits [i*HW +: HW].
REQ-014 SHALL have port any_z  output  1  OR of all z bits.

Function
REQ-015 Each channel SHALL be a Moore FSM with states S0..S(RUN_LEN), state index = run_cnt, counting current consecutive matches.
REQ-016 With en=1, match, state Sk (k<RUN_LEN) SHALL go to S(k+1).
REQ-017 With en=1, mismatch from any state SHALL go to S0.
REQ-018 With en=1, match in S(RUN_LEN): ovl=1 SHALL stay in S(RUN_LEN); ovl=0 SHALL go to S1.
REQ-019 With en=0, state SHALL hold regardless of w, pol, ovl.
REQ-020 z[i] SHALL be 1 iff channel i is in S(RUN_LEN), decoded from registered state only (no combinational path from w, pol, ovl, en).
REQ-021 Latency: z[i] SHALL rise in the cycle following the edge that samples the RUN_LEN-th consecutive match.
REQ-022 hit_cnt[i] SHALL increment by 1 on every edge where channel i enters S(RUN_LEN) from a lower state, and on every edge it stays in S(RUN_LEN) with en=1 and ovl=1.
REQ-023 hit_cnt SHALL saturate at 2^HW-1, never wrap.
REQ-024 clr=1 SHALL zero all hit counters on the next edge, taking priority over a simultaneous increment (result 0); clr SHALL act independent of en; clr SHALL NOT affect run state.
REQ-025 pol and ovl changes SHALL take effect on the same edge they are sampled, with no internal pipeline.
REQ-026 Channels SHALL be fully independent; any_z SHALL be combinational OR of registered z.

Reset
REQ-027 reset=1 SHALL asynchronously force every channel to S0, run_cnt=0, z=0, any_z=0, hit_cnt=0, regardless of en or clk.
REQ-028 Reset asserted mid-run SHALL discard partial runs; the first match after release SHALL go to S1.

Structure
REQ-029 Package run_det_pkg SHALL hold mode constants OVL_ON=1'b1 and OVL_OFF=1'b0, plus CW width helper function.
REQ-030 Per-channel FSM and hit counter SHALL be sub-module run_det_chan (params RUN_LEN, HW), instanced CH times by generate loop; top holds only flattening and any_z.

Verification (CH=2, RUN_LEN=3, HW=4, pol=1)
REQ-031 ch0 w=1,1,1,1,0 with ovl=1, en=1 -> run_cnt0 1,2,3,3,0; z0 high 2 cycles; hit_cnt0=2.
REQ-032 ch0 w=1 x6, ovl=0 -> run_cnt0 1,2,3,1,2,3; z0 pulses twice; hit_cnt0=2.
REQ-033 ch1 w=1,1,en=0 for 3 cycles (w toggling),1 -> run_cnt1 1,2,2,2,2,3; z1 rises only after final edge.
REQ-034 ch0 w=1 x20, ovl=1 -> hit_cnt0 saturates at 15; clr with an incrementing edge -> hit_cnt0=0, z0 stays 1.
REQ-035 pol=0, ch1 w=0,0,0 while ch0 w=1 -> z1=1, z0=0, any_z=1.
REQ-036 reset pulsed between clock edges while in S2 -> run_cnt=0, z=0 immediately; next w=1 -> S1.
